// File: rtl/br_flow_serializer_pkg.sv
// Shared helpers for the flow serializer slice.
package br_flow_serializer_pkg;

    // Index width for a counter over `count` positions; never narrower than one bit.
    function automatic int ser_flit_id_width(input int count);
        int width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << width) < count) begin
                width = width + 1;
            end
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/br_counter_incr.sv
// Wrapping up-counter over 0..MaxValue with a reinit that returns it to zero on an increment.
module br_counter_incr #(
    parameter int MaxValue = 1,
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             incr_valid,
    input  logic             reinit,
    output logic [Width-1:0] value
);

    localparam logic [Width-1:0] MaxValueW = Width'(MaxValue);

    // Step on each increment; reinit or reaching MaxValue folds back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (incr_valid) begin
            if (reinit || (value == MaxValueW)) begin
                value <= '0;
            end else begin
                value <= value + 1'b1;
            end
        end
    end

endmodule

// File: rtl/br_flow_serializer.sv
// Wide-to-narrow flow serializer: one wide push flit becomes SerializationRatio narrow
// pop flits, with trailing flits of a packet's final beat dropped. Zero latency; the only
// state is the narrow flit index.
module br_flow_serializer
    import br_flow_serializer_pkg::*;
#(
    parameter int PushWidth = 2,
    parameter int PopWidth = 1,
    parameter int MetadataWidth = 1,
    parameter bit SerializeMostSignificantFirst = 1,
    parameter bit EnableAssertFinalNotValid = 1,
    localparam int SerializationRatio = PushWidth / PopWidth,
    localparam int SerFlitIdWidth = ser_flit_id_width(SerializationRatio)
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      push_ready,
    input  logic                      push_valid,
    input  logic [PushWidth-1:0]      push_data,
    input  logic                      push_last,
    input  logic [SerFlitIdWidth-1:0] push_last_dont_care_count,
    input  logic [MetadataWidth-1:0]  push_metadata,
    input  logic                      pop_ready,
    output logic                      pop_valid,
    output logic [PopWidth-1:0]       pop_data,
    output logic                      pop_last,
    output logic [MetadataWidth-1:0]  pop_metadata
);

    logic final_flit;

    if (SerializationRatio == 1) begin : gen_passthru
        // One narrow flit per wide flit: nothing to count, every flit is final.
        logic unused_dont_care;
        assign unused_dont_care = ^push_last_dont_care_count;
        assign final_flit = 1'b1;
        assign pop_data = push_data;
    end else begin : gen_serialize
        localparam logic [SerFlitIdWidth-1:0] MaxIdx = SerFlitIdWidth'(SerializationRatio - 1);

        logic [SerFlitIdWidth-1:0] idx;
        logic [SerFlitIdWidth-1:0] care_max;
        logic [SerFlitIdWidth-1:0] slice_sel;
        logic [PopWidth-1:0]       slices [SerializationRatio];
        logic                      pop_fire;

        for (genvar k = 0; k < SerializationRatio; k++) begin : gen_slice
            assign slices[k] = push_data[PopWidth*k +: PopWidth];
        end

        // Last narrow flit kept for the current wide flit; a packet's final beat may stop early.
        always_comb begin
            care_max = MaxIdx;
            if (push_last) begin
                care_max = MaxIdx - push_last_dont_care_count;
            end
        end

        // Map the running index onto a slice according to the emission order.
        always_comb begin
            slice_sel = idx;
            if (SerializeMostSignificantFirst) begin
                slice_sel = MaxIdx - idx;
            end
        end

        assign final_flit = (idx == care_max);
        assign pop_data   = slices[slice_sel];
        assign pop_fire   = pop_valid & pop_ready;

        br_counter_incr #(
            .MaxValue(SerializationRatio - 1),
            .Width   (SerFlitIdWidth)
        ) u_idx_counter (
            .clk       (clk),
            .rst       (rst),
            .incr_valid(pop_fire),
            .reinit    (final_flit),
            .value     (idx)
        );
    end

    // The wide flit retires together with its last kept narrow flit.
    assign push_ready   = pop_ready & final_flit & ~rst;
    assign pop_valid    = push_valid & ~rst;
    assign pop_last     = push_valid & push_last & final_flit;
    assign pop_metadata = push_metadata;

`ifndef SYNTHESIS
    // Upstream must hold a wide flit steady until it is consumed.
    assert property (@(posedge clk) disable iff (rst)
        (push_valid && !push_ready) |=> (push_valid && $stable(push_data) && $stable(push_last)
            && $stable(push_last_dont_care_count) && $stable(push_metadata)))
        else $error("push flit changed while stalled");

    // Drop count must leave at least one narrow flit.
    assert property (@(posedge clk) disable iff (rst)
        push_valid |-> (int'(push_last_dont_care_count) < SerializationRatio))
        else $error("push_last_dont_care_count out of range");

    // Drop count is meaningful only on a packet's final beat.
    assert property (@(posedge clk) disable iff (rst)
        (push_valid && !push_last) |-> (push_last_dont_care_count == '0))
        else $error("push_last_dont_care_count nonzero without push_last");

    // Downstream sees a stalled narrow flit unchanged.
    assert property (@(posedge clk) disable iff (rst)
        (pop_valid && !pop_ready) |=> (pop_valid && $stable(pop_data) && $stable(pop_last)
            && $stable(pop_metadata)))
        else $error("pop flit changed while stalled");

    // Nothing may be left in flight at the end of a test.
    final begin
        if (EnableAssertFinalNotValid) begin
            assert (!push_valid && !pop_valid)
                else $error("valid still asserted at end of test");
        end
    end
`endif

endmodule

// File: tb/tb_br_flow_serializer.sv
// Self-checking bench: MSB-first and LSB-first 32->8 instances share one push/pop stimulus;
// a separate 8->8 instance covers the pass-through case.
module tb_br_flow_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        push_valid = 1'b0;
    logic [31:0] push_data = '0;
    logic        push_last = 1'b0;
    logic [1:0]  push_dc = '0;
    logic [2:0]  push_meta = '0;
    logic        pop_ready = 1'b0;

    logic        m_push_ready, m_pop_valid, m_pop_last;
    logic [7:0]  m_pop_data;
    logic [2:0]  m_pop_meta;
    logic        l_push_ready, l_pop_valid, l_pop_last;
    logic [7:0]  l_pop_data;
    logic [2:0]  l_pop_meta;

    logic        r1_push_valid = 1'b0;
    logic [7:0]  r1_push_data = '0;
    logic        r1_push_last = 1'b0;
    logic [0:0]  r1_dc = '0;
    logic [2:0]  r1_meta = '0;
    logic        r1_pop_ready = 1'b0;
    logic        r1_push_ready, r1_pop_valid, r1_pop_last;
    logic [7:0]  r1_pop_data;
    logic [2:0]  r1_pop_meta;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    br_flow_serializer #(.PushWidth(32), .PopWidth(8), .MetadataWidth(3),
                         .SerializeMostSignificantFirst(1), .EnableAssertFinalNotValid(1)) dut_msb (
        .clk(clk), .rst(rst), .push_ready(m_push_ready), .push_valid(push_valid),
        .push_data(push_data), .push_last(push_last), .push_last_dont_care_count(push_dc),
        .push_metadata(push_meta), .pop_ready(pop_ready), .pop_valid(m_pop_valid),
        .pop_data(m_pop_data), .pop_last(m_pop_last), .pop_metadata(m_pop_meta));

    br_flow_serializer #(.PushWidth(32), .PopWidth(8), .MetadataWidth(3),
                         .SerializeMostSignificantFirst(0), .EnableAssertFinalNotValid(1)) dut_lsb (
        .clk(clk), .rst(rst), .push_ready(l_push_ready), .push_valid(push_valid),
        .push_data(push_data), .push_last(push_last), .push_last_dont_care_count(push_dc),
        .push_metadata(push_meta), .pop_ready(pop_ready), .pop_valid(l_pop_valid),
        .pop_data(l_pop_data), .pop_last(l_pop_last), .pop_metadata(l_pop_meta));

    br_flow_serializer #(.PushWidth(8), .PopWidth(8), .MetadataWidth(3),
                         .SerializeMostSignificantFirst(1), .EnableAssertFinalNotValid(1)) dut_r1 (
        .clk(clk), .rst(rst), .push_ready(r1_push_ready), .push_valid(r1_push_valid),
        .push_data(r1_push_data), .push_last(r1_push_last), .push_last_dont_care_count(r1_dc),
        .push_metadata(r1_meta), .pop_ready(r1_pop_ready), .pop_valid(r1_pop_valid),
        .pop_data(r1_pop_data), .pop_last(r1_pop_last), .pop_metadata(r1_pop_meta));

    // Reference: byte j of the emission order is byte (3-j) for MSB-first, byte j for LSB-first.
    function automatic logic [7:0] exp_slice(input logic [31:0] d, input int j, input bit msb);
        logic [31:0] s;
        int k;
        k = msb ? (3 - j) : j;
        s = d >> (8 * k);
        return s[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one wide flit and follow it until it is consumed, checking every narrow flit.
    task automatic send_flit(input logic [31:0] d, input bit last, input int dc,
                             input logic [2:0] meta, input bit rnd, input logic [15:0] pat,
                             output int cycles);
        int  pos, n, cyc;
        bit  done, fin;
        push_valid = 1'b1;
        push_data  = d;
        push_last  = last;
        push_dc    = 2'(last ? dc : 0);
        push_meta  = meta;
        n = 4 - (last ? dc : 0);
        pos = 0; cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            pop_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc < 16) ? pat[cyc] : 1'b1);
            @(negedge clk);
            fin = (pos == n - 1);
            n_cmp++; if (m_pop_valid !== 1'b1 || l_pop_valid !== 1'b1) begin n_fail++;
                $display("FAIL pop_valid pos=%0d got msb=%b lsb=%b want=1", pos, m_pop_valid, l_pop_valid); end
            n_cmp++; if (m_pop_data !== exp_slice(d, pos, 1'b1)) begin n_fail++;
                $display("FAIL msb_data d=%h pos=%0d got=%h want=%h", d, pos, m_pop_data, exp_slice(d, pos, 1'b1)); end
            n_cmp++; if (l_pop_data !== exp_slice(d, pos, 1'b0)) begin n_fail++;
                $display("FAIL lsb_data d=%h pos=%0d got=%h want=%h", d, pos, l_pop_data, exp_slice(d, pos, 1'b0)); end
            n_cmp++; if (m_pop_last !== (last && fin) || l_pop_last !== (last && fin)) begin n_fail++;
                $display("FAIL pop_last pos=%0d got msb=%b lsb=%b want=%b", pos, m_pop_last, l_pop_last, last && fin); end
            n_cmp++; if (m_push_ready !== (pop_ready && fin) || l_push_ready !== (pop_ready && fin)) begin n_fail++;
                $display("FAIL push_ready pos=%0d got msb=%b lsb=%b want=%b", pos, m_push_ready, l_push_ready, pop_ready && fin); end
            n_cmp++; if (m_pop_meta !== meta || l_pop_meta !== meta) begin n_fail++;
                $display("FAIL pop_meta pos=%0d got msb=%0d lsb=%0d want=%0d", pos, m_pop_meta, l_pop_meta, meta); end
            step();
            if (pop_ready) begin
                if (fin) done = 1;
                else pos++;
            end
            cyc++;
        end
        n_cmp++; if (!done) begin n_fail++;
            $display("FAIL flit_timeout d=%h got=%0d_pops want=%0d_pops", d, pos, n); end
        cycles = cyc;
    endtask

    task automatic test_reset();
        push_valid = 1'b1; push_data = 32'hCAFE_0001; push_last = 1'b0; push_dc = '0;
        pop_ready = 1'b1; r1_push_valid = 1'b1; r1_pop_ready = 1'b1; r1_push_data = 8'h11;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (m_pop_valid !== 1'b0 || l_pop_valid !== 1'b0 || r1_pop_valid !== 1'b0) begin n_fail++;
                $display("FAIL reset_pop_valid got=%b%b%b want=000", m_pop_valid, l_pop_valid, r1_pop_valid); end
            n_cmp++; if (m_push_ready !== 1'b0 || l_push_ready !== 1'b0 || r1_push_ready !== 1'b0) begin n_fail++;
                $display("FAIL reset_push_ready got=%b%b%b want=000", m_push_ready, l_push_ready, r1_push_ready); end
            step();
        end
        rst = 1'b0; push_valid = 1'b0; r1_push_valid = 1'b0;
        step();
    endtask

    task automatic test_basic_msb();
        int c;
        send_flit(32'hBAADF00D, 1'b0, 0, 3'd1, 1'b0, 16'hFFFF, c);
        push_valid = 1'b0;
        n_cmp++; if (c !== 4) begin n_fail++; $display("FAIL basic_cycles got=%0d want=4", c); end
        step();
    endtask

    task automatic test_lsb_drop();
        int c;
        send_flit(32'h00ADF00D, 1'b1, 1, 3'd5, 1'b0, 16'hFFFF, c);
        push_valid = 1'b0;
        n_cmp++; if (c !== 3) begin n_fail++; $display("FAIL drop_cycles got=%0d want=3", c); end
        step();
    endtask

    task automatic test_backpressure();
        int c;
        send_flit(32'h0123_4567, 1'b0, 0, 3'd3, 1'b0, 16'hFFF9, c);
        push_valid = 1'b0;
        n_cmp++; if (c !== 6) begin n_fail++; $display("FAIL bp_cycles got=%0d want=6", c); end
        step();
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        send_flit(32'hA1B2_C3D4, 1'b0, 0, 3'd6, 1'b0, 16'hFFFF, c0);
        send_flit(32'h5E6F_7081, 1'b1, 0, 3'd2, 1'b0, 16'hFFFF, c1);
        push_valid = 1'b0;
        n_cmp++; if (c0 + c1 !== 8) begin n_fail++; $display("FAIL b2b_cycles got=%0d want=8", c0 + c1); end
        step();
    endtask

    task automatic test_reset_mid_packet();
        int c;
        push_valid = 1'b1; push_data = 32'h1234_5678; push_last = 1'b0; push_dc = '0;
        push_meta = 3'd4; pop_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            n_cmp++; if (m_pop_data !== exp_slice(push_data, j, 1'b1)) begin n_fail++;
                $display("FAIL midrst_pre pos=%0d got=%h want=%h", j, m_pop_data, exp_slice(push_data, j, 1'b1)); end
            step();
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (m_pop_valid !== 1'b0 || l_pop_valid !== 1'b0 || m_push_ready !== 1'b0) begin n_fail++;
                $display("FAIL midrst_hold got valid=%b%b ready=%b want=000", m_pop_valid, l_pop_valid, m_push_ready); end
            step();
        end
        rst = 1'b0;
        send_flit(32'h1234_5678, 1'b0, 0, 3'd4, 1'b0, 16'hFFFF, c);
        push_valid = 1'b0;
        step();
    endtask

    task automatic test_ratio1();
        r1_push_valid = 1'b1; r1_push_data = 8'h5A; r1_push_last = 1'b1; r1_meta = 3'd7;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                r1_push_data = 8'($urandom);
                r1_push_last = 1'($urandom_range(0, 1));
                r1_meta = 3'($urandom);
            end
            r1_pop_ready = (i == 1) ? 1'b0 : ((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            while (1) begin
                @(negedge clk);
                n_cmp++; if (r1_pop_valid !== 1'b1 || r1_pop_data !== r1_push_data) begin n_fail++;
                    $display("FAIL r1_data got v=%b d=%h want v=1 d=%h", r1_pop_valid, r1_pop_data, r1_push_data); end
                n_cmp++; if (r1_pop_last !== r1_push_last || r1_pop_meta !== r1_meta) begin n_fail++;
                    $display("FAIL r1_last_meta got %b/%0d want %b/%0d", r1_pop_last, r1_pop_meta, r1_push_last, r1_meta); end
                n_cmp++; if (r1_push_ready !== r1_pop_ready) begin n_fail++;
                    $display("FAIL r1_push_ready got=%b want=%b", r1_push_ready, r1_pop_ready); end
                step();
                if (r1_pop_ready) break;
                r1_pop_ready = 1'b1;
            end
        end
        r1_push_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        int c, dc;
        bit last;
        for (int i = 0; i < 24; i++) begin
            last = 1'($urandom_range(0, 1));
            dc = last ? $urandom_range(0, 3) : 0;
            send_flit($urandom, last, dc, 3'($urandom), 1'b1, 16'h0000, c);
            if ($urandom_range(0, 3) == 0) begin
                push_valid = 1'b0;
                @(negedge clk);
                n_cmp++; if (m_pop_valid !== 1'b0 || l_pop_valid !== 1'b0) begin n_fail++;
                    $display("FAIL idle_pop_valid got=%b%b want=00", m_pop_valid, l_pop_valid); end
                step();
            end
        end
        push_valid = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        test_reset();
        test_basic_msb();
        test_lsb_drop();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        test_ratio1();
        test_random();
        push_valid = 1'b0;
        r1_push_valid = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
